// File: rtl/countdown_timer.sv
// Loadable down-counter with optional divide-by-4 prescaler, one-shot or
// auto-reload expiry, and a registered one-cycle expiry pulse on Irq.
module countdown_timer #(
  parameter int WIDTH = 64
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             En,
  input  logic             Slt,
  input  logic             Mode,
  output logic [WIDTH-1:0] Count,
  output logic             Irq,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic [1:0]       pre_q, pre_d;
  logic             irq_q, irq_d;
  logic             tick;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      preset_q <= '0;
      pre_q    <= 2'd0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      preset_q <= preset_d;
      pre_q    <= pre_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    preset_d = preset_q;
    pre_d    = pre_q;
    irq_d    = 1'b0;
    tick     = 1'b0;
    if (Load) begin
      count_d  = LoadVal;
      preset_d = LoadVal;
      pre_d    = 2'd0;
      state_d  = (LoadVal != '0) ? COUNT : IDLE;
    end else if (state_q == COUNT && En) begin
      // With the prescaler selected, the tick lands on the fourth enabled cycle.
      if (Slt) begin
        pre_d = pre_q + 2'd1;
        tick  = (pre_q == 2'd3);
      end else begin
        tick  = 1'b1;
      end
      if (tick) begin
        if (count_q > ONE) begin
          count_d = count_q - ONE;
        end else if (count_q == ONE) begin
          irq_d = 1'b1;
          if (Mode) begin
            count_d = preset_q;
          end else begin
            count_d = '0;
            state_d = DONE;
          end
        end
      end
    end
  end

  assign Count     = count_q;
  assign Irq       = irq_q;
  assign Busy      = (state_q == COUNT);
  assign Done      = (state_q == DONE);
  assign state_dbg = state_q;

endmodule
